// File: rtl/sprite_blit_loader.sv
// Streams one sprite out of a character ROM into a frame-buffer write port,
// one pixel per cycle, optionally skipping a key colour.
module sprite_blit_loader #(
  parameter int CHAR_ID_WIDTH = 4,
  parameter int DATA_WIDTH = 12,
  parameter int X_WIDTH = 5,
  parameter int Y_WIDTH = 5,
  parameter int ROM_LATENCY = 1,
  parameter bit TRANSPARENT_EN = 1'b1,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT_COLOR = 12'hF0F,
  localparam int CHAR_ADDR_SIZE = X_WIDTH + Y_WIDTH
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [CHAR_ID_WIDTH-1:0]               character_id,
  input  logic [X_WIDTH-1:0]                     x,
  input  logic [Y_WIDTH-1:0]                     y,
  output logic [CHAR_ID_WIDTH+CHAR_ADDR_SIZE-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]                  rom_data,
  output logic                                   wr_en,
  output logic [CHAR_ADDR_SIZE-1:0]              wr_addr,
  output logic [DATA_WIDTH-1:0]                  wr_data,
  output logic [X_WIDTH-1:0]                     x_out,
  output logic [Y_WIDTH-1:0]                     y_out,
  output logic                                   busy,
  output logic                                   done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [CHAR_ADDR_SIZE-1:0] LAST_PIXEL = '1;
  localparam logic [2:0] DRAIN_LAST = 3'(ROM_LATENCY);

  logic [1:0]                state;
  logic [CHAR_ID_WIDTH-1:0]  id_q;
  logic [CHAR_ADDR_SIZE-1:0] counter;
  logic [2:0]                drain_cnt;
  logic [ROM_LATENCY-1:0]    pipe_vld;
  logic [CHAR_ADDR_SIZE-1:0] pipe_off [ROM_LATENCY];

  // Concatenation of two registers is id*CHAR_SIZE + counter without an adder.
  assign rom_addr = {id_q, counter};
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      id_q      <= '0;
      counter   <= '0;
      drain_cnt <= '0;
      x_out     <= '0;
      y_out     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            id_q    <= character_id;
            x_out   <= x;
            y_out   <= y;
            counter <= '0;
          end
        end
        FETCH: begin
          counter <= counter + 1'b1;
          if (counter == LAST_PIXEL) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          // Hold long enough for the last issued address to reach the write port.
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) pipe_off[i] <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      pipe_vld[0] <= (state == FETCH);
      pipe_off[0] <= counter;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_off[i] <= pipe_off[i-1];
      end
      // Skipped pixels still move the address/data so the sequence stays visible.
      wr_en <= pipe_vld[ROM_LATENCY-1] &&
               !(TRANSPARENT_EN && (rom_data == TRANSPARENT_COLOR));
      if (pipe_vld[ROM_LATENCY-1]) begin
        wr_addr <= pipe_off[ROM_LATENCY-1];
        wr_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blit_loader.sv
// Directed bench: a table of whole-sprite transfers plus hand-written corner
// sequences on three configurations (keyed L=1, unkeyed L=1, keyed L=3).
module tb_sprite_blit_loader;

  logic        clock;
  logic        reset;
  logic        start, start_nt, start_l3;
  logic [3:0]  character_id;
  logic [1:0]  x, y;
  logic        key_on;

  logic [7:0]  rom_addr, nt_rom_addr, l3_rom_addr;
  logic [11:0] rom_data, nt_rom_data, l3_rom_data;
  logic        wr_en, nt_wr_en, l3_wr_en;
  logic [3:0]  wr_addr, nt_wr_addr, l3_wr_addr;
  logic [11:0] wr_data, nt_wr_data, l3_wr_data;
  logic [1:0]  x_out, y_out, nt_x_out, nt_y_out, l3_x_out, l3_y_out;
  logic        busy, done, nt_busy, nt_done, l3_busy, l3_done;

  logic [11:0] rom_q = '0, nt_rom_q = '0, l3_a = '0, l3_b = '0, l3_c = '0;

  int total = 0;
  int bad = 0;

  sprite_blit_loader #(.X_WIDTH(2), .Y_WIDTH(2), .ROM_LATENCY(1), .TRANSPARENT_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .character_id(character_id),
    .x(x), .y(y), .rom_addr(rom_addr), .rom_data(rom_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .x_out(x_out), .y_out(y_out),
    .busy(busy), .done(done));

  sprite_blit_loader #(.X_WIDTH(2), .Y_WIDTH(2), .ROM_LATENCY(1), .TRANSPARENT_EN(1'b0)) dut_nt (
    .clock(clock), .reset(reset), .start(start_nt), .character_id(character_id),
    .x(x), .y(y), .rom_addr(nt_rom_addr), .rom_data(nt_rom_data), .wr_en(nt_wr_en),
    .wr_addr(nt_wr_addr), .wr_data(nt_wr_data), .x_out(nt_x_out), .y_out(nt_y_out),
    .busy(nt_busy), .done(nt_done));

  sprite_blit_loader #(.X_WIDTH(2), .Y_WIDTH(2), .ROM_LATENCY(3), .TRANSPARENT_EN(1'b1)) dut_l3 (
    .clock(clock), .reset(reset), .start(start_l3), .character_id(character_id),
    .x(x), .y(y), .rom_addr(l3_rom_addr), .rom_data(l3_rom_data), .wr_en(l3_wr_en),
    .wr_addr(l3_wr_addr), .wr_data(l3_wr_data), .x_out(l3_x_out), .y_out(l3_y_out),
    .busy(l3_busy), .done(l3_done));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM contents: data equals address, except word 50 becomes the key colour when key_on.
  function automatic logic [11:0] rom_fn(input int a);
    if (key_on && a == 50) return 12'hF0F;
    return 12'(a);
  endfunction

  always @(posedge clock) begin
    rom_q    <= rom_fn(int'(rom_addr));
    nt_rom_q <= rom_fn(int'(nt_rom_addr));
    l3_a     <= rom_fn(int'(l3_rom_addr));
    l3_b     <= l3_a;
    l3_c     <= l3_b;
  end
  assign rom_data    = rom_q;
  assign nt_rom_data = nt_rom_q;
  assign l3_rom_data = l3_c;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic launch(input logic [3:0] id, input int xv, input int yv);
    @(negedge clock);
    start = 1'b1;
    character_id = id;
    x = 2'(xv);
    y = 2'(yv);
  endtask

  // Follows one keyed L=1 transfer cycle by cycle; cycle c is the c-th cycle after the start edge.
  task automatic watch(input int base, input int exp_xo, input int exp_yo, input int exp_writes,
                       input int inj_cyc, input bit chain, input logic [3:0] nid,
                       input int nx, input int ny);
    int writes;
    logic [11:0] d;
    writes = 0;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clock);
      if (c <= 16) check("rom_addr", rom_addr, base + c - 1);
      if (c >= 3 && c <= 18) begin
        d = rom_fn(base + c - 3);
        check("wr_addr", wr_addr, c - 3);
        check("wr_data", wr_data, d);
        check("wr_en", wr_en, (d != 12'hF0F) ? 1 : 0);
      end else begin
        check("wr_en_quiet", wr_en, 0);
      end
      check("busy", busy, (c <= 18) ? 1 : 0);
      check("done", done, (c == 19) ? 1 : 0);
      check("x_out", x_out, exp_xo);
      check("y_out", y_out, exp_yo);
      if (wr_en) writes++;
      if (inj_cyc != 0 && c == inj_cyc) begin
        start = 1'b1;
        character_id = 4'd5;
        x = 2'd2;
        y = 2'd2;
      end else if (inj_cyc != 0 && c == inj_cyc + 1) begin
        start = 1'b0;
      end
      if (chain && c == 19) begin
        start = 1'b1;
        character_id = nid;
        x = 2'(nx);
        y = 2'(ny);
      end
    end
    check("write_count", writes, exp_writes);
  endtask

  // Side configurations: sel 1 = transparency disabled, sel 2 = ROM_LATENCY 3.
  task automatic side_run(input int sel, input int base, input int exp_writes, input int exp_done);
    int writes;
    int done_at;
    writes = 0;
    done_at = 0;
    @(negedge clock);
    character_id = 4'(base / 16);
    x = 2'd0;
    y = 2'd0;
    if (sel == 1) start_nt = 1'b1; else start_l3 = 1'b1;
    @(posedge clock);
    #1 begin start_nt = 1'b0; start_l3 = 1'b0; end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (sel == 1 && nt_wr_en) begin
        check("nt_wr_addr", nt_wr_addr, writes);
        check("nt_wr_data", nt_wr_data, rom_fn(base + writes));
        writes++;
      end
      if (sel == 2 && l3_wr_en) begin
        check("l3_wr_addr", l3_wr_addr, writes);
        check("l3_wr_data", l3_wr_data, rom_fn(base + writes));
        writes++;
      end
      if (done_at == 0 && ((sel == 1 && nt_done) || (sel == 2 && l3_done))) done_at = c;
    end
    check("side_writes", writes, exp_writes);
    check("side_done_latency", done_at, exp_done);
  endtask

  typedef struct {
    logic [3:0] id;
    int xv;
    int yv;
    bit key;
    int base;
    int exp_xo;
    int exp_yo;
    int exp_writes;
  } vec_t;

  vec_t vecs[4];
  int quiet_hits;

  initial begin
    // x/y are 2 bits wide here, so 7 and 9 fold to 3 and 1.
    vecs[0] = '{4'd3,  7, 9, 1'b0,  48, 3, 1, 16};
    vecs[1] = '{4'd0,  1, 2, 1'b0,   0, 1, 2, 16};
    vecs[2] = '{4'd15, 3, 0, 1'b0, 240, 3, 0, 16};
    vecs[3] = '{4'd3,  2, 3, 1'b1,  48, 2, 3, 15};

    reset = 1'b1;
    start = 1'b0;
    start_nt = 1'b0;
    start_l3 = 1'b0;
    character_id = 4'd9;
    x = 2'd3;
    y = 2'd3;
    key_on = 1'b0;

    // Start held high during reset must not launch anything.
    @(negedge clock);
    start = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_l3_busy", l3_busy, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      key_on = vecs[i].key;
      launch(vecs[i].id, vecs[i].xv, vecs[i].yv);
      watch(vecs[i].base, vecs[i].exp_xo, vecs[i].exp_yo, vecs[i].exp_writes, 0, 1'b0, 4'd0, 0, 0);
    end

    // Start pulse with another id while busy is ignored.
    key_on = 1'b0;
    launch(4'd3, 1, 1);
    watch(48, 1, 1, 16, 5, 1'b0, 4'd0, 0, 0);

    // Start in the done cycle chains straight into a second transfer.
    launch(4'd3, 0, 1);
    watch(48, 0, 1, 16, 0, 1'b1, 4'd1, 2, 3);
    watch(16, 2, 3, 16, 0, 1'b0, 4'd0, 0, 0);

    // Reset while write 6 is on the port aborts the transfer.
    launch(4'd3, 1, 2);
    @(posedge clock);
    #1 start = 1'b0;
    repeat (9) @(negedge clock);
    check("pre_abort_wr_addr", wr_addr, 6);
    check("pre_abort_wr_en", wr_en, 1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_outputs", {busy, done, wr_en, wr_addr, wr_data, rom_addr, x_out, y_out}, 0);
    reset = 1'b0;
    quiet_hits = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (wr_en || done || busy) quiet_hits++;
    end
    check("abort_quiet", quiet_hits, 0);
    launch(4'd0, 3, 3);
    watch(0, 3, 3, 16, 0, 1'b0, 4'd0, 0, 0);

    key_on = 1'b1;
    side_run(1, 48, 16, 19);
    key_on = 1'b0;
    side_run(2, 16, 16, 21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
